// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: forwards ALU results or performs one data-memory
// load/store with bounded wait states, then emits a registered write-back bundle.
module mem_access_stage #(
  parameter int unsigned DATA_W             = 16,
  parameter int unsigned REG_AW             = 5,
  parameter int unsigned MAX_WAIT           = 15,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_reg_dest,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_reg_dest,
  output logic              mem_err,
  input  logic              err_clr
);

  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cap_rw;
  logic [REG_AW-1:0] r_cap_dest;
  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_wb_reg_write;
  logic [REG_AW-1:0] r_wb_reg_dest;
  logic              r_mem_err;

  logic [CNT_W-1:0]  w_cnt;
  logic              w_mem_req;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_cap_rw;
  logic [REG_AW-1:0] w_cap_dest;
  logic              w_wb_valid;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_reg_write;
  logic [REG_AW-1:0] w_wb_reg_dest;
  logic              w_err_set;

  logic w_accept;
  logic w_is_mem;
  logic w_illegal;
  logic w_last_wait;

  assign in_ready    = (r_state == S_IDLE);
  assign w_accept    = in_valid && in_ready;
  assign w_is_mem    = in_mem_read ^ in_mem_write;
  assign w_illegal   = in_mem_read & in_mem_write;
  assign w_last_wait = (r_cnt == CNT_W'(MAX_WAIT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_IDLE) begin
      if (w_accept && w_is_mem) begin
        w_state_nxt = S_WAIT;
      end
    end else begin
      if (mem_ack || w_last_wait) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Next values of the registered memory and write-back outputs
  always_comb begin
    w_cnt          = r_cnt;
    w_mem_req      = r_mem_req;
    w_mem_we       = r_mem_we;
    w_mem_addr     = r_mem_addr;
    w_mem_wdata    = r_mem_wdata;
    w_cap_rw       = r_cap_rw;
    w_cap_dest     = r_cap_dest;
    w_wb_valid     = 1'b0;
    w_wb_data      = r_wb_data;
    w_wb_reg_write = 1'b0;
    w_wb_reg_dest  = r_wb_reg_dest;
    w_err_set      = 1'b0;

    if (r_state == S_IDLE) begin
      if (w_accept) begin
        if (w_is_mem) begin
          w_cnt       = '0;
          w_mem_req   = 1'b1;
          w_mem_we    = in_mem_write;
          w_mem_addr  = in_alu_result;
          w_mem_wdata = in_store_data;
          w_cap_rw    = in_reg_write;
          w_cap_dest  = in_reg_dest;
        end else begin
          w_wb_valid     = 1'b1;
          w_wb_data      = in_alu_result;
          w_wb_reg_write = in_reg_write & ~w_illegal;
          w_wb_reg_dest  = in_reg_dest;
          w_err_set      = w_illegal;
        end
      end
    end else begin
      if (mem_ack) begin
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_wb_valid     = 1'b1;
        w_wb_reg_dest  = r_cap_dest;
        w_wb_data      = r_mem_we ? r_mem_addr : mem_rdata;
        w_wb_reg_write = r_mem_we ? 1'b0 : r_cap_rw;
      end else if (w_last_wait) begin
        // Timeout: retire the instruction without a register write
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_wb_valid     = 1'b1;
        w_wb_data      = r_mem_addr;
        w_wb_reg_dest  = r_cap_dest;
        w_err_set      = 1'b1;
      end else begin
        w_cnt = r_cnt + CNT_W'(1);
      end
    end

    if (ZERO_REG_HARDWIRED && (w_wb_reg_dest == '0)) begin
      w_wb_reg_write = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_cap_rw       <= 1'b0;
      r_cap_dest     <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_data      <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_reg_dest  <= '0;
      r_mem_err      <= 1'b0;
    end else begin
      r_cnt          <= w_cnt;
      r_mem_req      <= w_mem_req;
      r_mem_we       <= w_mem_we;
      r_mem_addr     <= w_mem_addr;
      r_mem_wdata    <= w_mem_wdata;
      r_cap_rw       <= w_cap_rw;
      r_cap_dest     <= w_cap_dest;
      r_wb_valid     <= w_wb_valid;
      r_wb_data      <= w_wb_data;
      r_wb_reg_write <= w_wb_reg_write;
      r_wb_reg_dest  <= w_wb_reg_dest;
      // A new error takes priority over a coincident clear
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end else if (err_clr) begin
        r_mem_err <= 1'b0;
      end
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_reg_dest  = r_wb_reg_dest;
  assign mem_err      = r_mem_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single-cycle ops,
// hand-written sequences for loads, stores, timeout and reset in WAIT.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_alu_result;
  logic [15:0] in_store_data;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_reg_write;
  logic [4:0]  in_reg_dest;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        wb_reg_write;
  logic [4:0]  wb_reg_dest;
  logic        mem_err;
  logic        err_clr;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(
    .DATA_W(16), .REG_AW(5), .MAX_WAIT(15), .ZERO_REG_HARDWIRED(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_reg_dest(in_reg_dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
    .wb_reg_dest(wb_reg_dest), .mem_err(mem_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] alu;
    logic        rd;
    logic        wr;
    logic        rw;
    logic [4:0]  dest;
    logic        clr;
    logic        e_wbv;
    logic [15:0] e_data;
    logic        e_rw;
    logic [4:0]  e_dest;
    logic        e_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [15:0] alu,
                       input logic [15:0] sdata, input logic rw, input logic [4:0] dest);
    in_valid      = 1'b1;
    in_mem_read   = rd;
    in_mem_write  = wr;
    in_alu_result = alu;
    in_store_data = sdata;
    in_reg_write  = rw;
    in_reg_dest   = dest;
    step();
    in_valid     = 1'b0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_alu_result = '0; in_store_data = '0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0; in_reg_dest = '0;
    mem_rdata = '0; mem_ack = 1'b0; err_clr = 1'b0;

    // valid alu rd wr rw dest clr | wbv data rw dest err
    vecs[0] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 16'h0011, 1'b1, 5'd1, 1'b0};
    vecs[1] = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 16'h0022, 1'b1, 5'd2, 1'b0};
    vecs[2] = '{1'b1, 16'h0033, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 16'h0033, 1'b1, 5'd3, 1'b0};
    vecs[3] = '{1'b0, 16'h0099, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 16'h0033, 1'b0, 5'd3, 1'b0};
    vecs[4] = '{1'b1, 16'h0044, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 16'h0044, 1'b0, 5'd0, 1'b0};
    vecs[5] = '{1'b1, 16'h0055, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 16'h0055, 1'b0, 5'd6, 1'b1};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 16'h0055, 1'b0, 5'd6, 1'b0};
    vecs[7] = '{1'b1, 16'h0066, 1'b0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b1, 16'h0066, 1'b0, 5'd7, 1'b0};
    vecs[8] = '{1'b1, 16'h0077, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 16'h0077, 1'b0, 5'd8, 1'b1};
    vecs[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 16'h0077, 1'b0, 5'd8, 1'b0};

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Single-cycle operations
    for (int i = 0; i < 10; i++) begin
      in_valid      = vecs[i].valid;
      in_alu_result = vecs[i].alu;
      in_mem_read   = vecs[i].rd;
      in_mem_write  = vecs[i].wr;
      in_reg_write  = vecs[i].rw;
      in_reg_dest   = vecs[i].dest;
      err_clr       = vecs[i].clr;
      step();
      check($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
      check($sformatf("v%0d_wb_data", i), 32'(wb_data), 32'(vecs[i].e_data));
      check($sformatf("v%0d_wb_rw", i), 32'(wb_reg_write), 32'(vecs[i].e_rw));
      check($sformatf("v%0d_wb_dest", i), 32'(wb_reg_dest), 32'(vecs[i].e_dest));
      check($sformatf("v%0d_mem_err", i), 32'(mem_err), 32'(vecs[i].e_err));
      check($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'd0);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; err_clr = 1'b0;
    step();

    // Load 0x0040 -> r5, ack after 3 wait cycles
    issue(1'b0 ^ 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 5'd5);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ld_req_c%0d", k), 32'(mem_req), 32'd1);
      check($sformatf("ld_ready_c%0d", k), 32'(in_ready), 32'd0);
      check($sformatf("ld_wbv_c%0d", k), 32'(wb_valid), 32'd0);
      if (k == 0) begin
        check("ld_we", 32'(mem_we), 32'd0);
        check("ld_addr", 32'(mem_addr), 32'h0040);
      end
      if (k == 3) begin
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    check("ld_wb_valid", 32'(wb_valid), 32'd1);
    check("ld_wb_data", 32'(wb_data), 32'hBEEF);
    check("ld_wb_rw", 32'(wb_reg_write), 32'd1);
    check("ld_wb_dest", 32'(wb_reg_dest), 32'd5);
    check("ld_req_done", 32'(mem_req), 32'd0);
    check("ld_ready_done", 32'(in_ready), 32'd1);
    step();
    check("ld_wbv_pulse", 32'(wb_valid), 32'd0);

    // Store 0x1234 to 0x0100, ack in first cycle
    issue(1'b0, 1'b1, 16'h0100, 16'h1234, 1'b1, 5'd4);
    check("st_req", 32'(mem_req), 32'd1);
    check("st_we", 32'(mem_we), 32'd1);
    check("st_addr", 32'(mem_addr), 32'h0100);
    check("st_wdata", 32'(mem_wdata), 32'h1234);
    check("st_wbv_n1", 32'(wb_valid), 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("st_wb_valid", 32'(wb_valid), 32'd1);
    check("st_wb_rw", 32'(wb_reg_write), 32'd0);
    check("st_req_done", 32'(mem_req), 32'd0);

    // Load with no ack: timeout after MAX_WAIT cycles of mem_req
    step();
    issue(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 5'd4);
    cyc = 0;
    while (mem_req && cyc < 40) begin
      cyc++;
      step();
    end
    check("to_req_cycles", 32'(cyc), 32'd15);
    check("to_wb_valid", 32'(wb_valid), 32'd1);
    check("to_wb_rw", 32'(wb_reg_write), 32'd0);
    check("to_mem_err", 32'(mem_err), 32'd1);
    check("to_in_ready", 32'(in_ready), 32'd1);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_wbv", 32'(wb_valid), 32'd0);
    check("late_ack_ready", 32'(in_ready), 32'd1);
    check("err_sticky", 32'(mem_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_cleared", 32'(mem_err), 32'd0);

    // Reset while a load is waiting
    issue(1'b1, 1'b1, 16'h0300, 16'h0000, 1'b1, 5'd2);
    check("pre_rst_err", 32'(mem_err), 32'd1);
    issue(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 5'd2);
    step();
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_req", 32'(mem_req), 32'd0);
    check("mrst_addr", 32'(mem_addr), 32'd0);
    check("mrst_wb_data", 32'(wb_data), 32'd0);
    check("mrst_wb_dest", 32'(wb_reg_dest), 32'd0);
    check("mrst_mem_err", 32'(mem_err), 32'd0);
    check("mrst_wbv", 32'(wb_valid), 32'd0);
    #4;
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_req", 32'(mem_req), 32'd0);
    check("post_rst_wbv", 32'(wb_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
